// File: rtl/cbd_poly_scheduler_if.sv
// Bundle between the Kyber control FSM, the CBD poly scheduler and the
// small-polynomial generator. The scheduler uses the slave view. The master
// view is what the controller and generator together present to it.
interface cbd_poly_scheduler_if;
  // job request side
  logic         start;
  logic         mode;
  logic [255:0] seed;
  logic [7:0]   base_offset;
  logic         busy;
  logic         done;
  logic         error;

  // generator side; gen_M carries seed in its leading 256 bits, nonce in the trailing byte
  logic         gen_rst;
  logic         gen_active;
  logic [263:0] gen_M;
  logic [1:0]   gen_n_num;
  logic [7:0]   gen_offset;
  logic         gen_enw;

  modport master (
    output start, mode, seed, base_offset, gen_enw,
    input  busy, done, error, gen_rst, gen_active, gen_M, gen_n_num, gen_offset
  );

  modport slave (
    input  start, mode, seed, base_offset, gen_enw,
    output busy, done, error, gen_rst, gen_active, gen_M, gen_n_num, gen_offset
  );
endinterface

// File: rtl/cbd_poly_scheduler.sv
// Walks the CBD small-polynomial generator through one noise-vector job:
// KEYGEN = s[0..K-1], e[0..K-1]; ENCRYPT = r[0..K-1], e1[0..K-1], e2.
// All outputs are registered from the next-state decode.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | generator held in reset, waiting for start
// ARM    | PRF input / eta / offset presented, counters cleared
// FIRE   | generator released and activated
// WAIT   | counting RAM writes, watchdog running
// NEXT   | generator re-armed, advance nonce and poly index
// DONE   | one-cycle done pulse
// ERR    | watchdog expired, sticky error raised
module cbd_poly_scheduler #(
  parameter int K          = 2,
  parameter int POLY_WORDS = 32,
  parameter int TIMEOUT    = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  cbd_poly_scheduler_if.slave  bus
);

  localparam int PW  = $clog2(2 * K + 2);
  localparam int WCW = $clog2(POLY_WORDS + 1);

  localparam logic [PW-1:0]  NP_KEYGEN  = PW'(2 * K);
  localparam logic [PW-1:0]  NP_ENCRYPT = PW'(2 * K + 1);
  localparam logic [PW-1:0]  K_P        = PW'(K);
  localparam logic [WCW-1:0] WLAST      = WCW'(POLY_WORDS - 1);
  localparam logic [11:0]    WDOG_LOAD  = 12'(TIMEOUT);
  localparam logic [7:0]     OFF_STEP   = 8'(POLY_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FIRE, S_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t         state, state_nxt;
  logic           mode_q, mode_nxt;
  logic [PW-1:0]  p_q, p_nxt, p_inc, np;
  logic [7:0]     nonce_q, nonce_nxt;
  logic [WCW-1:0] wcnt_q, wcnt_nxt;
  logic [11:0]    wdog_q, wdog_nxt;   // cycles left before the watchdog fires
  logic           last_word;

  logic           busy_nxt, done_nxt, error_nxt, gen_rst_nxt, gen_active_nxt;
  logic [263:0]   gen_m_nxt;
  logic [1:0]     n_num_nxt;
  logic [7:0]     offset_nxt;

  assign p_inc     = p_q + PW'(1);
  assign np        = mode_q ? NP_ENCRYPT : NP_KEYGEN;
  assign last_word = bus.gen_enw && (wcnt_q == WLAST);

  // next-state, counters and output decode
  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_q;
    p_nxt      = p_q;
    nonce_nxt  = nonce_q;
    wcnt_nxt   = wcnt_q;
    wdog_nxt   = wdog_q;
    error_nxt  = bus.error;
    gen_m_nxt  = bus.gen_M;
    n_num_nxt  = bus.gen_n_num;
    offset_nxt = bus.gen_offset;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          mode_nxt   = bus.mode;
          p_nxt      = '0;
          nonce_nxt  = 8'd0;
          error_nxt  = 1'b0;
          gen_m_nxt  = {bus.seed, 8'd0};
          n_num_nxt  = 2'd1;
          offset_nxt = bus.base_offset;
          state_nxt  = S_ARM;
        end
      end
      S_ARM: begin
        wcnt_nxt  = '0;
        wdog_nxt  = WDOG_LOAD;
        state_nxt = S_FIRE;
      end
      S_FIRE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.gen_enw) wcnt_nxt = wcnt_q + WCW'(1);
        if (wdog_q != 12'd0) wdog_nxt = wdog_q - 12'd1;
        // completion has priority over a watchdog expiring in the same cycle
        if (last_word) begin
          state_nxt = S_NEXT;
        end else if (wdog_q == 12'd0) begin
          error_nxt = 1'b1;
          state_nxt = S_ERR;
        end
      end
      S_NEXT: begin
        p_nxt     = p_inc;
        nonce_nxt = nonce_q + 8'd1;
        if (p_inc == np) begin
          state_nxt = S_DONE;
        end else begin
          gen_m_nxt  = {bus.gen_M[263:8], nonce_q + 8'd1};
          offset_nxt = bus.gen_offset + OFF_STEP;  // wraps mod 256
          n_num_nxt  = (mode_q && (p_inc >= K_P)) ? 2'd2 : 2'd1;
          state_nxt  = S_ARM;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt       = !(state_nxt inside {S_IDLE, S_ERR});
    done_nxt       = (state_nxt == S_DONE);
    gen_active_nxt = (state_nxt inside {S_FIRE, S_WAIT});
    gen_rst_nxt    = !gen_active_nxt;
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      mode_q         <= 1'b0;
      p_q            <= '0;
      nonce_q        <= 8'd0;
      wcnt_q         <= '0;
      wdog_q         <= 12'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
      bus.gen_rst    <= 1'b1;
      bus.gen_active <= 1'b0;
      bus.gen_M      <= '0;
      bus.gen_n_num  <= 2'd1;
      bus.gen_offset <= 8'd0;
    end else begin
      state          <= state_nxt;
      mode_q         <= mode_nxt;
      p_q            <= p_nxt;
      nonce_q        <= nonce_nxt;
      wcnt_q         <= wcnt_nxt;
      wdog_q         <= wdog_nxt;
      bus.busy       <= busy_nxt;
      bus.done       <= done_nxt;
      bus.error      <= error_nxt;
      bus.gen_rst    <= gen_rst_nxt;
      bus.gen_active <= gen_active_nxt;
      bus.gen_M      <= gen_m_nxt;
      bus.gen_n_num  <= n_num_nxt;
      bus.gen_offset <= offset_nxt;
    end
  end

endmodule

// File: tb/tb_cbd_poly_scheduler.sv
// Bench for cbd_poly_scheduler: dut_a is K=2 with default watchdog, dut_b is
// K=4 with a short watchdog. One instance is exercised at a time through sel.
// Stimulus pushes per-poly expectations; the monitor pops them as the DUT fires.
module tb_cbd_poly_scheduler;

  localparam int TO_B = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cbd_poly_scheduler_if a_if ();
  cbd_poly_scheduler_if b_if ();

  cbd_poly_scheduler #(.K(2), .POLY_WORDS(32), .TIMEOUT(4095)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  cbd_poly_scheduler #(.K(4), .POLY_WORDS(32), .TIMEOUT(TO_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  logic         sel;
  logic         start, mode, enw;
  logic [255:0] seed;
  logic [7:0]   base;

  assign a_if.start       = start & ~sel;
  assign b_if.start       = start & sel;
  assign a_if.mode        = mode;
  assign b_if.mode        = mode;
  assign a_if.seed        = seed;
  assign b_if.seed        = seed;
  assign a_if.base_offset = base;
  assign b_if.base_offset = base;
  assign a_if.gen_enw     = enw & ~sel;
  assign b_if.gen_enw     = enw & sel;

  logic         m_busy, m_done, m_error, m_grst, m_active;
  logic [263:0] m_M;
  logic [1:0]   m_n;
  logic [7:0]   m_off;

  assign m_busy   = sel ? b_if.busy       : a_if.busy;
  assign m_done   = sel ? b_if.done       : a_if.done;
  assign m_error  = sel ? b_if.error      : a_if.error;
  assign m_grst   = sel ? b_if.gen_rst    : a_if.gen_rst;
  assign m_active = sel ? b_if.gen_active : a_if.gen_active;
  assign m_M      = sel ? b_if.gen_M      : a_if.gen_M;
  assign m_n      = sel ? b_if.gen_n_num  : a_if.gen_n_num;
  assign m_off    = sel ? b_if.gen_offset : a_if.gen_offset;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [263:0] act, input logic [263:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [263:0] m;
    logic [1:0]   n;
    logic [7:0]   off;
    int           len;
  } poly_t;

  poly_t exp_q[$];
  int    end_q[$];   // 0 = done expected, 1 = error expected

  // np polys; offs holds byte p at [8p+:8], ns holds n_num p at [2p+:2]
  task automatic push_job(input logic [255:0] sd, input int np, input logic [63:0] offs,
                          input logic [15:0] ns, input int len, input int end_kind);
    for (int p = 0; p < np; p++) begin
      poly_t e;
      e.m   = {sd, 8'(p)};
      e.n   = ns[2*p +: 2];
      e.off = offs[8*p +: 8];
      e.len = len;
      exp_q.push_back(e);
    end
    end_q.push_back(end_kind);
  endtask

  // generator model: 0 = writes every active cycle (incl. a stray one in FIRE),
  // 1 = stalls after 10 writes, 2 = 32nd write lands on the watchdog's last cycle
  int gen_mode = 0;
  int cyc = 0;
  always @(negedge clk) begin
    if (rst || !m_active) begin
      cyc = 0;
      enw = 1'b0;
    end else begin
      cyc++;
      case (gen_mode)
        0:       enw = 1'b1;
        1:       enw = (cyc >= 2) && (cyc <= 11);
        default: enw = (cyc - 1 >= TO_B - 30) && (cyc - 1 <= TO_B + 1);
      endcase
    end
  end

  // monitor / scoreboard
  poly_t        cur;
  logic         prev_act = 1'b0, prev_err = 1'b0, prev_done = 1'b0;
  logic [263:0] prev_M = '0;
  logic [1:0]   prev_n = '0;
  logic [7:0]   prev_off = '0;
  int           act_len = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      end_q.delete();
      prev_act  = 1'b0;
      prev_err  = 1'b0;
      prev_done = 1'b0;
      act_len   = 0;
    end else begin
      if (m_active && !prev_act) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_poly", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("arm_gen_M", prev_M, cur.m);
          chk("arm_n_num", prev_n, cur.n);
          chk("arm_offset", prev_off, cur.off);
        end
        chk("fire_gen_rst", m_grst, 0);
        act_len = 0;
      end
      if (m_active) act_len++;
      if (!m_active && prev_act) begin
        chk("active_len", act_len, cur.len);
        chk("wait_gen_M", prev_M, cur.m);
        chk("wait_n_num", prev_n, cur.n);
        chk("wait_offset", prev_off, cur.off);
        chk("rearm_gen_rst", m_grst, 1);
      end
      if (m_done) begin
        if (end_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("end_kind_done", end_q.pop_front(), 0);
        chk("polys_left_at_done", exp_q.size(), 0);
        chk("error_at_done", m_error, 0);
        chk("busy_at_done", m_busy, 1);
        chk("done_pulse_width", prev_done, 0);
      end
      if (m_error && !prev_err) begin
        if (end_q.size() == 0) chk("unexpected_error", 1, 0);
        else chk("end_kind_error", end_q.pop_front(), 1);
        chk("polys_left_at_error", exp_q.size(), 0);
        chk("busy_at_error", m_busy, 0);
      end
      prev_act  = m_active;
      prev_err  = m_error;
      prev_done = m_done;
      prev_M    = m_M;
      prev_n    = m_n;
      prev_off  = m_off;
    end
  end

  task automatic issue(input logic md, input logic [255:0] sd, input logic [7:0] bo);
    @(negedge clk);
    mode  = md;
    seed  = sd;
    base  = bo;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int   n = 0;
    logic pending;
    while ((end_q.size() != 0 || m_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    pending = (end_q.size() != 0) || m_busy;
    chk("job_finished", pending, 0);
    if (pending) begin
      exp_q.delete();
      end_q.delete();
    end
  endtask

  task automatic wait_active(input logic [7:0] nonce, input int budget);
    int n = 0;
    while (!(m_active && m_M[7:0] == nonce) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("reached_poly", (m_active && m_M[7:0] == nonce), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] s1, s2, s5, s6, s3, s4, s7;
    int           n;
    s1 = {32{8'hA5}};
    s2 = {4{64'h0123_4567_89AB_CDEF}};
    s5 = {8{32'hDEAD_BEEF}};
    s6 = {16{16'hC3C3}};
    s3 = {32{8'h3C}};
    s4 = {8{32'h0F1E_2D3C}};
    s7 = {4{64'hA5A5_0000_FFFF_5A5A}};

    rst = 1'b1; sel = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; base = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_error", a_if.error, 0);
    chk("rst_gen_active", a_if.gen_active, 0);
    chk("rst_gen_rst", a_if.gen_rst, 1);
    chk("rst_gen_M", a_if.gen_M, 0);
    chk("rst_n_num", a_if.gen_n_num, 1);
    chk("rst_offset", a_if.gen_offset, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_gen_rst", a_if.gen_rst, 1);

    // 1: K=2 KEYGEN from 0x00
    push_job(s1, 4, 64'h0000_0000_6040_2000, 16'h0055, 33, 0);
    issue(1'b0, s1, 8'h00);
    wait_end(400);

    // 2: K=2 ENCRYPT from 0x10, then a start landing on the DONE cycle
    push_job(s2, 5, 64'h0000_0090_7050_3010, 16'h02A5, 33, 0);
    issue(1'b1, s2, 8'h10);
    n = 0;
    while (!m_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("enc_done_seen", m_done, 1);
    seed  = s5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", m_busy, 0);
    repeat (3) @(negedge clk);
    chk("start_in_done_no_job", m_busy | m_active, 0);
    wait_end(400);

    // 5a: start during WAIT with different seed/mode/base is ignored
    push_job(s5, 4, 64'h0000_0000_A080_6040, 16'h0055, 33, 0);
    issue(1'b0, s5, 8'h40);
    wait_active(8'd1, 200);
    repeat (10) @(negedge clk);
    mode  = 1'b1;
    seed  = ~s5;
    base  = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(400);

    // 6: reset mid-WAIT of poly 2, then a fresh job from nonce 0
    push_job(s6, 4, 64'h0000_0000_6040_2000, 16'h0055, 33, 0);
    issue(1'b0, s6, 8'h00);
    wait_active(8'd2, 300);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", a_if.busy, 0);
    chk("rst_mid_gen_rst", a_if.gen_rst, 1);
    chk("rst_mid_gen_active", a_if.gen_active, 0);
    chk("rst_mid_gen_M", a_if.gen_M, 0);
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    push_job(s6, 4, 64'h0000_0000_6040_2000, 16'h0055, 33, 0);
    issue(1'b0, s6, 8'h00);
    wait_end(400);

    // switch to the K=4 instance
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);

    // 3: K=4 KEYGEN from 0xF0, offsets wrap
    push_job(s3, 8, 64'hD0B0_9070_5030_10F0, 16'h5555, 33, 0);
    issue(1'b0, s3, 8'hF0);
    wait_end(600);

    // 4: generator stalls after 10 writes -> watchdog error
    gen_mode = 1;
    push_job(s4, 1, 64'h0, 16'h0001, TO_B + 2, 1);
    issue(1'b0, s4, 8'h00);
    wait_end(400);
    repeat (3) @(negedge clk);
    chk("err_sticky", m_error, 1);
    chk("err_busy", m_busy, 0);
    gen_mode = 0;
    push_job(s4, 8, 64'hE0C0_A080_6040_2000, 16'h5555, 33, 0);
    issue(1'b0, s4, 8'h00);
    chk("err_cleared_on_start", m_error, 0);
    chk("busy_after_start", m_busy, 1);
    wait_end(600);

    // 5b: last write and watchdog expiry coincide on every poly
    gen_mode = 2;
    push_job(s7, 8, 64'hE0C0_A080_6040_2000, 16'h5555, TO_B + 2, 0);
    issue(1'b0, s7, 8'h00);
    wait_end(2000);
    chk("coincide_no_error", m_error, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
